// File: rtl/exp_lut_pkg.sv
// Shared constants and the e^x lookup table for the Q3.3 -> Q4.4 exponential unit.
package exp_lut_pkg;

   localparam int unsigned EXP_IN_W  = 6;
   localparam int unsigned EXP_OUT_W = 8;

   localparam logic [EXP_OUT_W-1:0] EXP_ONE      = 8'h10;  // 1.0 in Q4.4
   localparam logic [EXP_IN_W-1:0]  EXP_SAT_CODE = 6'd23;  // first code whose e^x clamps

   // entry[k] = min(255, round_half_up(16 * e^(s/8))), s = k as signed 6-bit.
   // Codes 23..31 fall through to the default and clamp to full scale.
   function automatic logic [EXP_OUT_W-1:0] exp_entry(input logic [EXP_IN_W-1:0] k);
      logic [EXP_OUT_W-1:0] v;
      case (k)
         // Non-negative operands 0.000 .. +2.750
         6'd0:  v = 8'd16;
         6'd1:  v = 8'd18;
         6'd2:  v = 8'd21;
         6'd3:  v = 8'd23;
         6'd4:  v = 8'd26;
         6'd5:  v = 8'd30;
         6'd6:  v = 8'd34;
         6'd7:  v = 8'd38;
         6'd8:  v = 8'd43;
         6'd9:  v = 8'd49;
         6'd10: v = 8'd56;
         6'd11: v = 8'd63;
         6'd12: v = 8'd72;
         6'd13: v = 8'd81;
         6'd14: v = 8'd92;
         6'd15: v = 8'd104;
         6'd16: v = 8'd118;
         6'd17: v = 8'd134;
         6'd18: v = 8'd152;
         6'd19: v = 8'd172;
         6'd20: v = 8'd195;
         6'd21: v = 8'd221;
         6'd22: v = 8'd250;
         // Negative operands -4.000 .. -0.125
         6'd32, 6'd33, 6'd34, 6'd35, 6'd36: v = 8'd0;
         6'd37, 6'd38, 6'd39, 6'd40, 6'd41,
         6'd42, 6'd43, 6'd44, 6'd45:        v = 8'd1;
         6'd46, 6'd47, 6'd48, 6'd49:        v = 8'd2;
         6'd50, 6'd51:                      v = 8'd3;
         6'd52, 6'd53:                      v = 8'd4;
         6'd54, 6'd55:                      v = 8'd5;
         6'd56: v = 8'd6;
         6'd57: v = 8'd7;
         6'd58: v = 8'd8;
         6'd59: v = 8'd9;
         6'd60: v = 8'd10;
         6'd61: v = 8'd11;
         6'd62: v = 8'd12;
         6'd63: v = 8'd14;
         default: v = 8'd255;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/exp_lut_rom.sv
// Combinational e^x table: operand code -> {saturation flag, Q4.4 value}.
module exp_lut_rom
   import exp_lut_pkg::*;
(
   input  logic [5:0] x,
   output logic [7:0] value,
   output logic       sat
);

   // Table lookup; overflow only for non-negative codes at or above the clamp point
   always_comb begin
      value = exp_entry(x);
      sat   = ~x[5] & (x >= EXP_SAT_CODE);
   end

endmodule

// File: rtl/exp_lut.sv
// Registered fixed-point exponential: one-cycle latency, one result per clock, no stalls.
module exp_lut
   import exp_lut_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [5:0] x,
   output logic       out_valid,
   output logic [7:0] exp_out,
   output logic       out_sat
);

   logic [7:0] rom_value;
   logic       rom_sat;

   logic       out_valid_d, out_valid_q;
   logic [7:0] exp_d, exp_q;
   logic       sat_d, sat_q;

   exp_lut_rom u_rom (
      .x     (x),
      .value (rom_value),
      .sat   (rom_sat)
   );

   // Capture a new result on valid input; otherwise hold the last one
   always_comb begin
      out_valid_d = in_valid;
      exp_d       = exp_q;
      sat_d       = sat_q;
      if (in_valid) begin
         exp_d = rom_value;
         sat_d = rom_sat;
      end
   end

   // Output stage; reset wins over any input accepted in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         exp_q       <= 8'h00;
         sat_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         exp_q       <= exp_d;
         sat_q       <= sat_d;
      end
   end

   assign out_valid = out_valid_q;
   assign exp_out   = exp_q;
   assign out_sat   = sat_q;

endmodule

// File: tb/tb_exp_lut.sv
// Self-checking bench for exp_lut against a real-arithmetic e^x reference.
module tb_exp_lut;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [5:0] x = 6'd0;
   logic       out_valid;
   logic [7:0] exp_out;
   logic       out_sat;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: what the outputs should show after the last edge
   logic       m_valid = 1'b0;
   logic [7:0] m_exp = 8'h00;
   logic       m_sat = 1'b0;

   exp_lut dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .x         (x),
      .out_valid (out_valid),
      .exp_out   (exp_out),
      .out_sat   (out_sat)
   );

   always #5 clk = ~clk;

   function automatic real ref_raw(input logic [5:0] k);
      int s;
      s = int'($signed(k));
      return 16.0 * $exp(real'(s) / 8.0);
   endfunction

   function automatic logic [7:0] ref_val(input logic [5:0] k);
      real v;
      int  r;
      v = ref_raw(k);
      if (v > 255.0) return 8'd255;
      r = int'($floor(v + 0.5));
      return 8'(r);
   endfunction

   function automatic logic ref_sat(input logic [5:0] k);
      return ref_raw(k) > 255.0;
   endfunction

   // Drive one cycle of stimulus, advance past the edge, update the model
   task automatic apply(input logic iv, input logic [5:0] xv, input logic rv);
      in_valid = iv;
      x        = xv;
      rst      = rv;
      @(posedge clk);
      #1;
      if (rv) begin
         m_valid = 1'b0;
         m_exp   = 8'h00;
         m_sat   = 1'b0;
      end else begin
         m_valid = iv;
         if (iv) begin
            m_exp = ref_val(xv);
            m_sat = ref_sat(xv);
         end
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 6'd8, 1'b1);
         vectors++;
         if ({out_valid, exp_out, out_sat} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset cyc%0d: got v=%b e=%h s=%b, need 0/00/0",
                     i, out_valid, exp_out, out_sat);
         end
      end
      apply(1'b0, 6'd8, 1'b0);
      vectors++;
      if ({out_valid, exp_out, out_sat} !== 10'b0) begin
         miscompares++;
         $display("FAIL reset_release: got v=%b e=%h s=%b, need 0/00/0",
                  out_valid, exp_out, out_sat);
      end
   endtask

   task automatic test_key_points();
      logic [5:0] xs [6] = '{6'd0, 6'd8, 6'd16, 6'h38, 6'h3F, 6'h20};
      logic [7:0] es [6] = '{8'h10, 8'h2B, 8'h76, 8'h06, 8'h0E, 8'h00};
      for (int i = 0; i < 6; i++) begin
         apply(1'b1, xs[i], 1'b0);
         vectors++;
         if (out_valid !== 1'b1 || exp_out !== es[i] || out_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL key x=%h: got v=%b e=%h s=%b, need 1/%h/0",
                     xs[i], out_valid, exp_out, out_sat, es[i]);
         end
      end
   endtask

   task automatic test_saturation();
      logic [5:0] xs [3] = '{6'd22, 6'd23, 6'd31};
      logic [7:0] es [3] = '{8'd250, 8'd255, 8'd255};
      logic       ss [3] = '{1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, xs[i], 1'b0);
         vectors++;
         if (out_valid !== 1'b1 || exp_out !== es[i] || out_sat !== ss[i]) begin
            miscompares++;
            $display("FAIL sat x=%0d: got v=%b e=%0d s=%b, need 1/%0d/%b",
                     xs[i], out_valid, exp_out, out_sat, es[i], ss[i]);
         end
      end
   endtask

   task automatic test_sweep();
      logic [7:0] seen [64];
      for (int k = 0; k < 64; k++) begin
         apply(1'b1, 6'(k), 1'b0);
         seen[k] = exp_out;
         vectors++;
         if (out_valid !== 1'b1 || exp_out !== m_exp || out_sat !== m_sat) begin
            miscompares++;
            $display("FAIL sweep x=%0d: got v=%b e=%0d s=%b, need 1/%0d/%b",
                     k, out_valid, exp_out, out_sat, m_exp, m_sat);
         end
      end
      // Signed order: codes 32..63 then 0..31
      for (int s = -31; s <= 31; s++) begin
         vectors++;
         if (seen[(s + 64) % 64] < seen[(s + 63) % 64]) begin
            miscompares++;
            $display("FAIL monotonic s=%0d: got %0d after %0d, need non-decreasing",
                     s, seen[(s + 64) % 64], seen[(s + 63) % 64]);
         end
      end
   endtask

   task automatic test_valid_gaps();
      logic       ivs [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [5:0] xvs [4] = '{6'd8, 6'd8, 6'd16, 6'd16};
      logic [7:0] es  [4] = '{8'h2B, 8'h2B, 8'h76, 8'h76};
      for (int i = 0; i < 4; i++) begin
         apply(ivs[i], xvs[i], 1'b0);
         vectors++;
         if (out_valid !== ivs[i] || exp_out !== es[i] || out_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL gap step%0d: got v=%b e=%h s=%b, need %b/%h/0",
                     i, out_valid, exp_out, out_sat, ivs[i], es[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      for (int k = 0; k < 40; k++) begin
         apply(1'b1, 6'(k), k == 20);
         vectors++;
         if (k == 20) begin
            if (out_valid !== 1'b0 || exp_out !== 8'h00 || out_sat !== 1'b0) begin
               miscompares++;
               $display("FAIL midreset: got v=%b e=%h s=%b, need 0/00/0",
                        out_valid, exp_out, out_sat);
            end
         end else if (out_valid !== 1'b1 || exp_out !== m_exp || out_sat !== m_sat) begin
            miscompares++;
            $display("FAIL midreset_stream x=%0d: got v=%b e=%0d s=%b, need 1/%0d/%b",
                     k, out_valid, exp_out, out_sat, m_exp, m_sat);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         apply(1'($urandom_range(0, 3) != 0), 6'($urandom), 1'($urandom_range(0, 49) == 0));
         vectors++;
         if (out_valid !== m_valid || exp_out !== m_exp || out_sat !== m_sat) begin
            miscompares++;
            $display("FAIL random i=%0d: got v=%b e=%0d s=%b, need %b/%0d/%b",
                     i, out_valid, exp_out, out_sat, m_valid, m_exp, m_sat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_key_points();
      test_saturation();
      test_sweep();
      test_valid_gaps();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
